// File: rtl/vga_pkg.sv
// Shared types, timing defaults and frame-buffer geometry for the vga_out scan-out engine.
package vga_pkg;

    typedef enum logic [1:0] {
        SYNC        = 2'd0,
        BACK_PORCH  = 2'd1,
        ACTIVE      = 2'd2,
        FRONT_PORCH = 2'd3
    } seg_t;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } fetch_t;

    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;

    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;

    localparam int unsigned SCALE_DEF        = 5;
    localparam int unsigned FB_WORDS_PER_ROW = 4;
    localparam int unsigned FB_ROWS          = 96;

    function automatic seg_t next_seg(input seg_t s);
        seg_t n;
        unique case (s)
            SYNC:        n = BACK_PORCH;
            BACK_PORCH:  n = ACTIVE;
            ACTIVE:      n = FRONT_PORCH;
            FRONT_PORCH: n = SYNC;
            default:     n = SYNC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical segment counters and registered active-low sync generation.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] h_count_o,
    output logic [8:0] v_count_o,
    output seg_t       h_state_o,
    output seg_t       v_state_o,
    output logic       h_sync_n_o,
    output logic       v_sync_n_o,
    output logic       line_end_o
);

    logic [9:0] h_count_q, h_count_d, h_last;
    logic [8:0] v_count_q, v_count_d, v_last;
    seg_t       h_state_q, h_state_d;
    seg_t       v_state_q, v_state_d;
    logic       h_sync_n_q, v_sync_n_q;
    logic       line_end;

    always_comb begin
        h_last = '0;
        unique case (h_state_q)
            SYNC:        h_last = 10'(H_SYNC - 1);
            BACK_PORCH:  h_last = 10'(H_BP - 1);
            ACTIVE:      h_last = 10'(H_ACTIVE - 1);
            FRONT_PORCH: h_last = 10'(H_FP - 1);
            default:     h_last = '0;
        endcase
    end

    always_comb begin
        v_last = '0;
        unique case (v_state_q)
            SYNC:        v_last = 9'(V_SYNC - 1);
            BACK_PORCH:  v_last = 9'(V_BP - 1);
            ACTIVE:      v_last = 9'(V_ACTIVE - 1);
            FRONT_PORCH: v_last = 9'(V_FP - 1);
            default:     v_last = '0;
        endcase
    end

    assign line_end = (h_state_q == FRONT_PORCH) && (h_count_q == h_last);

    always_comb begin
        h_count_d = h_count_q + 10'd1;
        h_state_d = h_state_q;
        if (h_count_q == h_last) begin
            h_count_d = '0;
            h_state_d = next_seg(h_state_q);
        end

        v_count_d = v_count_q;
        v_state_d = v_state_q;
        if (line_end) begin
            v_count_d = v_count_q + 9'd1;
            if (v_count_q == v_last) begin
                v_count_d = '0;
                v_state_d = next_seg(v_state_q);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_count_q  <= '0;
            v_count_q  <= '0;
            h_state_q  <= SYNC;
            v_state_q  <= SYNC;
            h_sync_n_q <= 1'b1;
            v_sync_n_q <= 1'b1;
        end else begin
            h_count_q  <= h_count_d;
            v_count_q  <= v_count_d;
            h_state_q  <= h_state_d;
            v_state_q  <= v_state_d;
            // Syncs lag the counters by one clock to line up with the registered pixel.
            h_sync_n_q <= (h_state_q != SYNC);
            v_sync_n_q <= (v_state_q != SYNC);
        end
    end

    assign h_count_o  = h_count_q;
    assign v_count_o  = v_count_q;
    assign h_state_o  = h_state_q;
    assign v_state_o  = v_state_q;
    assign h_sync_n_o = h_sync_n_q;
    assign v_sync_n_o = v_sync_n_q;
    assign line_end_o = line_end;

endmodule

// File: rtl/vga_out.sv
// 640x480 monochrome VGA scan-out: 5x5 upscale of a 128x96 1-bpp SRAM frame buffer.
// Defining VGA_TEST_PATTERN_EN replaces the SRAM fetch with an internal checkerboard.
module vga_out
    import vga_pkg::*;
#(
    parameter logic [31:0] FB_BASE_ADDR = 32'h0,
    parameter int unsigned H_SYNC       = H_SYNC_DEF,
    parameter int unsigned H_BP         = H_BP_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_FP         = H_FP_DEF,
    parameter int unsigned V_SYNC       = V_SYNC_DEF,
    parameter int unsigned V_BP         = V_BP_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_FP         = V_FP_DEF,
    parameter int unsigned SCALE        = SCALE_DEF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] SRAM_data_in,
    input  logic        SRAM_busy,
    output logic        data_en,
    output logic        h_out,
    output logic        v_out,
    output logic        pixel_data,
    output logic [31:0] word_address_dest,
    output logic [3:0]  byte_select,
    output logic [1:0]  VGA_state,
    output logic [9:0]  h_count,
    output logic [8:0]  v_count,
    output logic [1:0]  h_state,
    output logic [1:0]  v_state
);

    localparam logic [2:0] SubLast = 3'(SCALE - 1);

    seg_t   h_seg, v_seg;
    logic   line_end;
    logic   h_act, v_act, visible;

    logic [6:0] x_q, x_d, y_q, y_d;
    logic [2:0] xs_q, xs_d, ys_q, ys_d;
    logic       pixel_q, pixel_d;
    fetch_t     fetch_q, fetch_d;

    vga_timing #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) u_timing (
        .clk_i      (clk),
        .rst_i      (nrst),
        .h_count_o  (h_count),
        .v_count_o  (v_count),
        .h_state_o  (h_seg),
        .v_state_o  (v_seg),
        .h_sync_n_o (h_out),
        .v_sync_n_o (v_out),
        .line_end_o (line_end)
    );

    assign h_state = h_seg;
    assign v_state = v_seg;
    assign h_act   = (h_seg == ACTIVE);
    assign v_act   = (v_seg == ACTIVE);
    assign visible = h_act && v_act;

    // x/y stay zero outside their active segment so each line and frame starts at 0.
    always_comb begin
        x_d  = x_q;
        xs_d = xs_q;
        if (!h_act) begin
            x_d  = '0;
            xs_d = '0;
        end else if (xs_q == SubLast) begin
            xs_d = '0;
            x_d  = x_q + 7'd1;
        end else begin
            xs_d = xs_q + 3'd1;
        end

        y_d  = y_q;
        ys_d = ys_q;
        if (!v_act) begin
            y_d  = '0;
            ys_d = '0;
        end else if (line_end) begin
            if (ys_q == SubLast) begin
                ys_d = '0;
                y_d  = y_q + 7'd1;
            end else begin
                ys_d = ys_q + 3'd1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic unused_sram;
    assign unused_sram       = ^{SRAM_data_in, SRAM_busy};
    assign data_en           = 1'b0;
    assign byte_select       = 4'h0;
    assign word_address_dest = FB_BASE_ADDR;

    always_comb begin
        pixel_d = 1'b0;
        fetch_d = BLANK;
        if (visible) begin
            pixel_d = x_q[0] ^ y_q[0];
            fetch_d = FETCH;
        end
    end
`else
    logic [4:0] bit_idx;

    assign data_en     = visible;
    assign byte_select = visible ? 4'hF : 4'h0;
    // Four 32-bit words per stored row; x[6:5] picks the word, x[4:0] the bit (MSB first).
    assign word_address_dest = visible ? FB_BASE_ADDR + {23'd0, y_q, x_q[6:5]} : FB_BASE_ADDR;
    assign bit_idx           = 5'd31 - x_q[4:0];

    always_comb begin
        pixel_d = 1'b0;
        fetch_d = BLANK;
        if (visible) begin
            if (SRAM_busy) begin
                fetch_d = STALL;
            end else begin
                fetch_d = FETCH;
                pixel_d = SRAM_data_in[bit_idx];
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            x_q     <= '0;
            xs_q    <= '0;
            y_q     <= '0;
            ys_q    <= '0;
            pixel_q <= 1'b0;
            fetch_q <= BLANK;
        end else begin
            x_q     <= x_d;
            xs_q    <= xs_d;
            y_q     <= y_d;
            ys_q    <= ys_d;
            pixel_q <= pixel_d;
            fetch_q <= fetch_d;
        end
    end

    assign pixel_data = pixel_q;
    assign VGA_state  = fetch_q;

endmodule

// File: tb/tb_vga_out.sv
// Bench for vga_out: shortened vertical timing, positional model checked every cycle.
module tb_vga_out;

    localparam int HS = 96, HB = 48, HA = 640, HF = 16;
    localparam int VS = 2, VB = 3, VA = 15, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] sram_rd;
    logic        busy;
    logic        data_en, h_out, v_out, pixel_data;
    logic [31:0] word_address_dest;
    logic [3:0]  byte_select;
    logic [1:0]  vga_state, h_state, v_state;
    logic [9:0]  h_count;
    logic [8:0]  v_count;

    logic [31:0] mem [0:383];
    int t_q;
    int total = 0;
    int bad = 0;
    int pass_no = 0;
    bit running = 0;

    // Expectations for the registered outputs at the next clock.
    logic pend_pix, pend_h, pend_v;
    int   pend_st;

    always #5 clk = ~clk;

    assign sram_rd = (word_address_dest < 32'd384) ? mem[word_address_dest[8:0]] : 32'h0;

    vga_out #(
        .V_SYNC   (VS),
        .V_BP     (VB),
        .V_ACTIVE (VA),
        .V_FP     (VF)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .SRAM_data_in      (sram_rd),
        .SRAM_busy         (busy),
        .data_en           (data_en),
        .h_out             (h_out),
        .v_out             (v_out),
        .pixel_data        (pixel_data),
        .word_address_dest (word_address_dest),
        .byte_select       (byte_select),
        .VGA_state         (vga_state),
        .h_count           (h_count),
        .v_count           (v_count),
        .h_state           (h_state),
        .v_state           (v_state)
    );

    // Elapsed clocks since the last reset.
    always @(posedge clk or posedge nrst) begin
        if (nrst) t_q <= 0;
        else      t_q <= t_q + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t_q, act, exp);
        end
    endtask

    function automatic void seg_of(input int pos, input int a, input int b, input int c,
                                   output int st, output int cnt);
        if (pos < a)              begin st = 0; cnt = pos;         end
        else if (pos < a + b)     begin st = 1; cnt = pos - a;     end
        else if (pos < a + b + c) begin st = 2; cnt = pos - a - b; end
        else                      begin st = 3; cnt = pos - a - b - c; end
    endfunction

    always @(negedge clk) begin : cmp
        int hs, hc, vs, vc, x, y, bi;
        logic de;
        logic [31:0] addr, w;
        if (running) begin
            seg_of(t_q % HT, HS, HB, HA, hs, hc);
            seg_of((t_q / HT) % VT, VS, VB, VA, vs, vc);
            de   = (hs == 2) && (vs == 2);
            x    = hc / 5;
            y    = vc / 5;
            addr = de ? 32'(y * 4 + x / 32) : 32'h0;

            chk("h_count", 32'(h_count), 32'(hc));
            chk("v_count", 32'(v_count), 32'(vc));
            chk("h_state", 32'(h_state), 32'(hs));
            chk("v_state", 32'(v_state), 32'(vs));
            chk("data_en", 32'(data_en), 32'(de));
            chk("byte_select", 32'(byte_select), de ? 32'hF : 32'h0);
            chk("word_address", word_address_dest, addr);

            if (t_q == 0) begin
                chk("pixel_rst", 32'(pixel_data), 32'h0);
                chk("vga_state_rst", 32'(vga_state), 32'h0);
                chk("h_out_rst", 32'(h_out), 32'h1);
                chk("v_out_rst", 32'(v_out), 32'h1);
            end else begin
                chk("pixel_data", 32'(pixel_data), 32'(pend_pix));
                chk("vga_state", 32'(vga_state), 32'(pend_st));
                chk("h_out", 32'(h_out), 32'(pend_h));
                chk("v_out", 32'(v_out), 32'(pend_v));
            end

            // Hand-computed anchors that pin the model itself.
            if (pass_no == 1) begin
                case (t_q)
                    1:     begin chk("lit_hcnt1", 32'(h_count), 1);
                                 chk("lit_hout1", 32'(h_out), 0); end
                    96:    begin chk("lit_hstate96", 32'(h_state), 1);
                                 chk("lit_hcnt96", 32'(h_count), 0); end
                    97:    chk("lit_hout97", 32'(h_out), 1);
                    800:   chk("lit_vcnt800", 32'(v_count), 1);
                    1600:  begin chk("lit_vstate1600", 32'(v_state), 1);
                                 chk("lit_vout1600", 32'(v_out), 0); end
                    1601:  chk("lit_vout1601", 32'(v_out), 1);
                    4144:  chk("lit_de4144", 32'(data_en), 1);
                    4145:  chk("lit_pix4145", 32'(pixel_data), 1);
                    4149:  chk("lit_pix4149", 32'(pixel_data), 1);
                    4150:  chk("lit_pix4150", 32'(pixel_data), 0);
                    7345:  chk("lit_pix7345", 32'(pixel_data), 1);
                    8145:  chk("lit_pix8145", 32'(pixel_data), 0);
                    17599: begin chk("lit_last_h", 32'(h_count), 15);
                                 chk("lit_last_v", 32'(v_count), 1); end
                    17600: begin chk("lit_wrap_vstate", 32'(v_state), 0);
                                 chk("lit_wrap_vcnt", 32'(v_count), 0); end
                    21745: begin chk("lit_stall_state", 32'(vga_state), 2);
                                 chk("lit_stall_pix", 32'(pixel_data), 0); end
                    25904: chk("lit_addr_y1x32", word_address_dest, 5);
                    39344: chk("lit_ff_pix_bp", 32'(pixel_data), 0);
                    39345: chk("lit_ff_pix", 32'(pixel_data), 1);
                    default: ;
                endcase
            end

            pend_h = (hs != 0);
            pend_v = (vs != 0);
            if (!de) begin
                pend_pix = 1'b0;
                pend_st  = 0;
            end else if (busy) begin
                pend_pix = 1'b0;
                pend_st  = 2;
            end else begin
                w        = mem[addr[8:0]];
                bi       = 31 - (x % 32);
                pend_pix = w[bi];
                pend_st  = 1;
            end
        end
    end

    // mode 0: never busy; mode 1: busy for the whole first active line and sporadically later.
    task automatic run(input int n, input int mode);
        int line;
        repeat (n) begin
            @(posedge clk);
            #2;
            line = (t_q / HT) % VT;
            if (mode == 0)              busy = 1'b0;
            else if (line == VS + VB)   busy = 1'b1;
            else                        busy = (line >= VS + VB + 2) && (t_q % 7 == 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0d got=timeout want=finish", t_q);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < 384; i++) mem[i] = 32'h0;
        mem[0]  = 32'h8000_0000;
        pass_no = 1;
        running = 1;
        repeat (2) @(posedge clk);
        #2 nrst = 1'b0;

        run(FRAME, 0);
        for (int i = 0; i < 384; i++) mem[i] = $urandom;
        run(FRAME, 1);
        for (int i = 0; i < 384; i++) mem[i] = 32'hFFFF_FFFF;
        run(FRAME, 0);

        // Asynchronous reset in the middle of an active line.
        pass_no = 2;
        run(6 * HT + 300, 0);
        nrst = 1'b1;
        @(posedge clk);
        #2 nrst = 1'b0;
        run(2 * HT, 0);

        running = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_out.md
Name: vga_out

Overview:
- 640x480 @ 60 Hz monochrome VGA scan-out engine, 25 MHz pixel clock.
- Generates HSYNC/VSYNC and the per-axis timing state/counters.
- Fetches a 1-bpp 128x96 frame buffer (384 x 32-bit words) from SRAM and upscales each stored pixel 5x5 onto the screen.
- Sits between the SRAM arbiter and the VGA connector; SRAM read data is combinational from the address.

Parameters:
- FB_BASE_ADDR, 32'h0, word address of frame-buffer word 0.
- H_SYNC/H_BP/H_ACTIVE/H_FP, 96/48/640/16, horizontal segment lengths in clocks (800 total).
- V_SYNC/V_BP/V_ACTIVE/V_FP, 2/33/480/10, vertical segment lengths in lines (525 total).
- SCALE, 5, screen pixels per stored pixel on each axis.

Ports:
- clk  in  1  pixel clock, 25 MHz, rising edge.
- nrst  in  1  reset; one clock; reset is asynchronous and active-high (asserted when nrst=1).
- SRAM_data_in  in  32  word at word_address_dest, valid the same cycle.
- SRAM_busy  in  1  SRAM unavailable this cycle.
- data_en  out  1  read request; high in the visible area.
- h_out  out  1  HSYNC, active-low.
- v_out  out  1  VSYNC, active-low.
- pixel_data  out  1  pixel output, 1 = white.
- word_address_dest  out  32  SRAM word address.
- byte_select  out  4  byte enables.
- VGA_state  out  2  fetch state.
- h_count  out  10  clock count within the current h segment.
- v_count  out  9  line count within the current v segment.
- h_state  out  2  horizontal segment.
- v_state  out  2  vertical segment.

Behaviour:
- State encoding (h_state and v_state): 0 SYNC, 1 BACK_PORCH, 2 ACTIVE, 3 FRONT_PORCH; order SYNC->BACK->ACTIVE->FRONT->SYNC.
- Reset values: all counters 0; h_state=v_state=SYNC; VGA_state=0; pixel_data=0; data_en=0; byte_select=0; word_address_dest=FB_BASE_ADDR; h_out=v_out=1.
- h_count behaviour:
  - Increments every clock once reset is released (first post-reset edge gives h_count=1).
  - At count = segment length - 1 it returns to 0 and h_state advances.
  - SYNC runs 0..95, BACK 0..47, ACTIVE 0..639, FRONT 0..15.
- v_count behaviour:
  - Advances one step on the clock where h_state=FRONT and h_count=15 (end of line).
  - Wraps per segment the same way: SYNC 0..1, BACK 0..32, ACTIVE 0..479, FRONT 0..9.
  - The end of v FRONT line 9 wraps to v SYNC line 0, i.e. the frame wraps.
- Sync outputs: h_out=0 iff h_state=SYNC; v_out=0 iff v_state=SYNC. Both are registered one clock late so they stay aligned with pixel_data.
- Visible area: data_en = (h_state==ACTIVE && v_state==ACTIVE), combinational.
- Address and byte select:
  - byte_select = 4'hF when data_en is high, else 4'h0.
  - x = h_count/5 (0..127), y = v_count/5 (0..95), both from sub-counters, no divider.
  - word_address_dest = FB_BASE_ADDR + y*4 + x[6:5].
  - Bit index = 31 - x[4:0], MSB-first.
- pixel_data is registered, latency 1 clock: pixel_data <= (data_en && !SRAM_busy) ? SRAM_data_in[bit] : 0.
- VGA_state (registered, same latency):
  - 0 BLANK: data_en=0.
  - 1 FETCH: data_en=1 and SRAM_busy=0.
  - 2 STALL: data_en=1 and SRAM_busy=1; that pixel outputs black.
  - 3 unused.
- Timing never stalls; SRAM_busy affects only pixel data.
- An asynchronous reset mid-frame restarts at h SYNC / v SYNC with count 0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: SRAM is ignored; data_en and byte_select are forced to 0; pixel_data is a registered checkerboard, pixel_data = x[0]^y[0] inside the visible area, else 0; VGA_state reports 0/1 as if SRAM_busy=0.
- Undefined: normal frame-buffer fetch.

Decomposition:
- Package vga_pkg holds:
  - the seg_t enum (SYNC, BACK_PORCH, ACTIVE, FRONT_PORCH);
  - the fetch_t enum (BLANK, FETCH, STALL);
  - the timing localparam defaults;
  - the FB_WORDS_PER_ROW=4 and FB_ROWS=96 constants.
- Sub-module vga_timing: h/v counters, segment states, sync generation. vga_out adds the scaler, address generation and pixel register.

Test Plan:
- Hold nrst=1 for 2 clocks -> h_count=0, v_count=0, pixel_data=0, VGA_state=0. Release -> next clock h_count=1.
- Free-run one line -> h_state 0 for 96 clocks, 1 for 48, 2 for 640, 3 for 16. h_count wraps to 0 at each boundary; h_out low exactly 96 clocks; v_count 0->1 after 800 clocks.
- Free-run a full frame (420000 clocks) -> v segments of 2/33/480/10 lines; v_out low 1600 clocks; returns to v SYNC, v_count=0.
- Memory all 32'hFFFFFFFF, SRAM_busy=0 -> pixel_data=1 exactly in visible clocks (+1 latency), 0 elsewhere. word_address_dest runs 0..3 per row, row y=95 uses 380..383.
- Word 0 = 32'h80000000, rest 0 -> only the first 5x5 screen block (x 0..4, y 0..4) is white.
- SRAM_busy=1 during the first active line -> VGA_state=2 and pixel_data=0 there; h/v timing unchanged.
